// File: rtl/alu_pipe.sv
// alu_pipe: fully pipelined CGRA PE ALU with stall freeze, signed or
// unsigned compare/shift modes, logic ops and an illegal-opcode flag.
//
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   Stall           freeze every stage (outputs too); inputs ignored
//   In_Valid        operation present on Opcode / ALU_In0..2
//   Opcode          4-bit operation select
//   ALU_In0..2      DWIDTH-bit operands
//   Out_Valid       one pulse per accepted op, PIPE cycles later
//   ALU_Out         result (holds between valid results)
//   Illegal         reserved opcode flag, qualified by Out_Valid
//
// Register chain: stage 1 (operands), stages 2..PIPE (result),
// then the output register, so an op accepted at edge N is
// visible after edge N+PIPE.

module alu_pipe #(
  parameter int          DWIDTH = 32,
  parameter int          PIPE   = 3,
  parameter int unsigned SIGNED = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              In_Valid,
  input  logic [3:0]        Opcode,
  input  logic [DWIDTH-1:0] ALU_In0,
  input  logic [DWIDTH-1:0] ALU_In1,
  input  logic [DWIDTH-1:0] ALU_In2,
  output logic              Out_Valid,
  output logic [DWIDTH-1:0] ALU_Out,
  output logic              Illegal
);

  localparam int SW   = $clog2(DWIDTH);
  localparam int NMID = PIPE - 1;

  localparam logic [3:0] OP_IDLE   = 4'b0000;
  localparam logic [3:0] OP_MULADD = 4'b0001;
  localparam logic [3:0] OP_MULSUB = 4'b0010;
  localparam logic [3:0] OP_ADDADD = 4'b0011;
  localparam logic [3:0] OP_ADDSUB = 4'b0100;
  localparam logic [3:0] OP_SUBSUB = 4'b0101;
  localparam logic [3:0] OP_PHI    = 4'b0110;
  localparam logic [3:0] OP_GT     = 4'b0111;
  localparam logic [3:0] OP_LET    = 4'b1000;
  localparam logic [3:0] OP_SHL    = 4'b1001;
  localparam logic [3:0] OP_SHR    = 4'b1010;
  localparam logic [3:0] OP_AND    = 4'b1011;
  localparam logic [3:0] OP_OR     = 4'b1100;
  localparam logic [3:0] OP_XOR    = 4'b1101;

  // ---------------- stage 1: operand capture ----------------
  logic              s1_v_q;
  logic              s1_v_d;
  logic [3:0]        s1_op_q;
  logic [DWIDTH-1:0] s1_a_q;
  logic [DWIDTH-1:0] s1_b_q;
  logic [DWIDTH-1:0] s1_c_q;

  // IDLE is a bubble even when flagged valid.
  assign s1_v_d = In_Valid && (Opcode != OP_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_v_q <= 1'b0;
    end else if (!Stall) begin
      s1_v_q  <= s1_v_d;
      s1_op_q <= Opcode;
      s1_a_q  <= ALU_In0;
      s1_b_q  <= ALU_In1;
      s1_c_q  <= ALU_In2;
    end
  end

  // ---------------- execute (feeds stage 2) ----------------
  logic [SW-1:0]     sh;
  logic [DWIDTH-1:0] prod;
  logic [DWIDTH-1:0] shr;
  logic              gt;
  logic [DWIDTH-1:0] ex_res_d;
  logic              ex_ill_d;

  assign sh   = s1_b_q[SW-1:0];
  assign prod = s1_a_q * s1_b_q;

  always_comb begin
    gt  = 1'b0;
    shr = '0;
    if (SIGNED != 0) begin
      gt  = $signed(s1_a_q) > $signed(s1_b_q);
      shr = $unsigned($signed(s1_a_q) >>> sh);
    end else begin
      gt  = s1_a_q > s1_b_q;
      shr = s1_a_q >> sh;
    end
  end

  always_comb begin
    ex_res_d = '0;
    ex_ill_d = 1'b0;
    case (s1_op_q)
      OP_MULADD: ex_res_d = prod + s1_c_q;
      OP_MULSUB: ex_res_d = prod - s1_c_q;
      OP_ADDADD: ex_res_d = s1_a_q + s1_b_q + s1_c_q;
      OP_ADDSUB: ex_res_d = s1_a_q + s1_b_q - s1_c_q;
      OP_SUBSUB: ex_res_d = s1_a_q - s1_b_q - s1_c_q;
      OP_PHI: begin
        ex_res_d = (s1_a_q != '0) ? s1_b_q : s1_c_q;
      end
      OP_GT:  ex_res_d = {{(DWIDTH-1){1'b0}}, gt};
      OP_LET: ex_res_d = {{(DWIDTH-1){1'b0}}, !gt};
      OP_SHL: ex_res_d = s1_a_q << sh;
      OP_SHR: ex_res_d = shr;
      OP_AND: ex_res_d = s1_a_q & s1_b_q;
      OP_OR:  ex_res_d = s1_a_q | s1_b_q;
      OP_XOR: ex_res_d = s1_a_q ^ s1_b_q;
      OP_IDLE: ex_res_d = '0;
      default: ex_ill_d = 1'b1;
    endcase
  end

  // ---------------- stages 2..PIPE: result delay ----------------
  logic [NMID-1:0]   mid_v_q;
  logic [NMID-1:0]   mid_ill_q;
  logic [DWIDTH-1:0] mid_res_q [NMID];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mid_v_q <= '0;
    end else if (!Stall) begin
      mid_v_q[0]   <= s1_v_q;
      mid_ill_q[0] <= ex_ill_d;
      mid_res_q[0] <= ex_res_d;
      for (int i = 1; i < NMID; i++) begin
        mid_v_q[i]   <= mid_v_q[i-1];
        mid_ill_q[i] <= mid_ill_q[i-1];
        mid_res_q[i] <= mid_res_q[i-1];
      end
    end
  end

  // ---------------- output register ----------------
  logic              out_v_q;
  logic              out_ill_q;
  logic [DWIDTH-1:0] out_res_q;

  // Data and Illegal only load on a valid result so they hold
  // across bubbles; the valid bit itself pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_v_q   <= 1'b0;
      out_ill_q <= 1'b0;
      out_res_q <= '0;
    end else if (!Stall) begin
      out_v_q <= mid_v_q[NMID-1];
      if (mid_v_q[NMID-1]) begin
        out_ill_q <= mid_ill_q[NMID-1];
        out_res_q <= mid_res_q[NMID-1];
      end
    end
  end

  assign Out_Valid = out_v_q;
  assign ALU_Out   = out_res_q;
  assign Illegal   = out_ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe, one DUT per
// compare/shift mode sharing the same stimulus.

module tb_alu_pipe;

  localparam int DW = 32;
  localparam int PP = 3;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Stall = 1'b0;
  logic          In_Valid = 1'b0;
  logic [3:0]    Opcode = 4'd0;
  logic [DW-1:0] In0 = '0;
  logic [DW-1:0] In1 = '0;
  logic [DW-1:0] In2 = '0;

  logic          ov_s, ill_s, ov_u, ill_u;
  logic [DW-1:0] out_s, out_u;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] q_s[$];
  logic [32:0] q_u[$];

  logic stall_e = 1'b0;
  logic rst_e = 1'b1;

  always #5 clk = ~clk;

  alu_pipe #(.DWIDTH(DW), .PIPE(PP), .SIGNED(1)) dut_s (
    .Clk(clk), .Reset(Reset), .Stall(Stall),
    .In_Valid(In_Valid), .Opcode(Opcode),
    .ALU_In0(In0), .ALU_In1(In1), .ALU_In2(In2),
    .Out_Valid(ov_s), .ALU_Out(out_s), .Illegal(ill_s)
  );

  alu_pipe #(.DWIDTH(DW), .PIPE(PP), .SIGNED(0)) dut_u (
    .Clk(clk), .Reset(Reset), .Stall(Stall),
    .In_Valid(In_Valid), .Opcode(Opcode),
    .ALU_In0(In0), .ALU_In1(In1), .ALU_In2(In2),
    .Out_Valid(ov_u), .ALU_Out(out_u), .Illegal(ill_u)
  );

  function automatic logic [32:0] model(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input bit          sgn
  );
    logic [31:0] r;
    logic        ill;
    logic        g;
    int          n;
    r   = '0;
    ill = 1'b0;
    if (sgn) g = (a ^ 32'h8000_0000) > (b ^ 32'h8000_0000);
    else     g = a > b;
    n = int'(b[4:0]);
    case (op)
      4'd1:  r = a * b + c;
      4'd2:  r = a * b - c;
      4'd3:  r = a + b + c;
      4'd4:  r = a + b - c;
      4'd5:  r = a - b - c;
      4'd6:  r = (a != 0) ? b : c;
      4'd7:  r = {31'd0, g};
      4'd8:  r = {31'd0, ~g};
      4'd9:  r = a << n;
      4'd10: begin
        r = a >> n;
        if (sgn && a[31]) r = r | ~(32'hFFFF_FFFF >> n);
      end
      4'd11: r = a & b;
      4'd12: r = a | b;
      4'd13: r = a ^ b;
      4'd14, 4'd15: ill = 1'b1;
      default: r = '0;
    endcase
    return {ill, r};
  endfunction

  task automatic drive(
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic        st
  );
    In_Valid = v;
    Opcode   = op;
    In0      = a;
    In1      = b;
    In2      = c;
    Stall    = st;
    if (v && !st && !Reset && op != 4'd0) begin
      q_s.push_back(model(op, a, b, c, 1'b1));
      q_u.push_back(model(op, a, b, c, 1'b0));
    end
  endtask

  always @(posedge clk) begin
    stall_e <= Stall;
    rst_e   <= Reset;
  end

  // Scoreboard: a result is new when Out_Valid is seen after a
  // non-stalled, non-reset edge; held copies during stall skip.
  always @(negedge clk) begin
    if (!rst_e && !stall_e && ov_s) begin
      vectors++;
      if (q_s.size() == 0) begin
        miscompares++;
        $display("FAIL sb_s spurious: Out_Valid=1 out=%h, required none",
                 out_s);
      end else begin
        logic [32:0] e;
        e = q_s.pop_front();
        if ({ill_s, out_s} !== e) begin
          miscompares++;
          $display("FAIL sb_s: got ill=%b out=%h, required ill=%b out=%h",
                   ill_s, out_s, e[32], e[31:0]);
        end
      end
    end
    if (!rst_e && !stall_e && ov_u) begin
      vectors++;
      if (q_u.size() == 0) begin
        miscompares++;
        $display("FAIL sb_u spurious: Out_Valid=1 out=%h, required none",
                 out_u);
      end else begin
        logic [32:0] e;
        e = q_u.pop_front();
        if ({ill_u, out_u} !== e) begin
          miscompares++;
          $display("FAIL sb_u: got ill=%b out=%h, required ill=%b out=%h",
                   ill_u, out_u, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({ov_s, ill_s, out_s} !== 34'd0 ||
        {ov_u, ill_u, out_u} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset: s=%b/%b/%h u=%b/%b/%h, required 0/0/0",
               ov_s, ill_s, out_s, ov_u, ill_u, out_u);
    end
    Reset = 1'b0;
    q_s.delete();
    q_u.delete();
  endtask

  task automatic test_latency();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) drive(1'b1, 4'd1, 3, 4, 5, 1'b0);
      else        drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
      vectors++;
      if (k == 3) begin
        if (!(ov_s === 1'b1 && out_s === 32'd17 && ill_s === 1'b0)) begin
          miscompares++;
          $display("FAIL latency k=3: v=%b out=%h ill=%b, required 1/11/0",
                   ov_s, out_s, ill_s);
        end
      end else if (ov_s !== 1'b0) begin
        miscompares++;
        $display("FAIL latency k=%0d: Out_Valid=%b, required 0", k, ov_s);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(1'b1, 4'd2, 32'h0001_0000, 32'h0001_0000, 1, 1'b0);
      else if (k == 1) drive(1'b1, 4'd3, 32'hFFFF_FFFF, 1, 1, 1'b0);
      else             drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
      if (k == 3) begin
        vectors++;
        if (!(ov_u === 1'b1 && out_u === 32'hFFFF_FFFF)) begin
          miscompares++;
          $display("FAIL wrap_mulsub: v=%b out=%h, required 1/ffffffff",
                   ov_u, out_u);
        end
      end
      if (k == 4) begin
        vectors++;
        if (!(ov_u === 1'b1 && out_u === 32'h0000_0001)) begin
          miscompares++;
          $display("FAIL wrap_addadd: v=%b out=%h, required 1/00000001",
                   ov_u, out_u);
        end
      end
    end
  endtask

  task automatic test_modes();
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(1'b1, 4'd7, 32'hFFFF_FFFF, 1, 0, 1'b0);
      else if (k == 1) drive(1'b1, 4'd10, 32'h8000_0000, 4, 0, 1'b0);
      else             drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
      if (k == 3) begin
        vectors++;
        if (out_s !== 32'd0 || out_u !== 32'd1) begin
          miscompares++;
          $display("FAIL mode_gt: s=%h u=%h, required 0/1", out_s, out_u);
        end
      end
      if (k == 4) begin
        vectors++;
        if (out_s !== 32'hF800_0000 || out_u !== 32'h0800_0000) begin
          miscompares++;
          $display("FAIL mode_shr: s=%h u=%h, required f8000000/08000000",
                   out_s, out_u);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        ev [10];
    logic [31:0] ed [10];
    ev = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    ed = '{0, 0, 0, 1, 1, 1, 2, 3, 4, 4};
    for (int k = 0; k < 10; k++) begin
      if (k < 4)
        drive(1'b1, 4'd3, k + 1, 0, 0, 1'b0);
      else if (k < 6)
        drive(1'b1, 4'd3, 99, 0, 0, 1'b1);
      else
        drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
      vectors++;
      if (ov_s !== ev[k] || (ev[k] && out_s !== ed[k])) begin
        miscompares++;
        $display("FAIL stall k=%0d: v=%b out=%h, required v=%b out=%h",
                 k, ov_s, out_s, ev[k], ed[k]);
      end
    end
  endtask

  task automatic test_reserved_idle();
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      drive(1'b1, 4'd14, 5, 6, 7, 1'b0);
      else if (k == 1) drive(1'b1, 4'd0, 8, 9, 10, 1'b0);
      else             drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
      if (k == 3) begin
        vectors++;
        if (!(ov_s === 1'b1 && out_s === 32'd0 && ill_s === 1'b1)) begin
          miscompares++;
          $display("FAIL reserved: v=%b out=%h ill=%b, required 1/0/1",
                   ov_s, out_s, ill_s);
        end
      end
      if (k > 3) begin
        vectors++;
        if (ov_s !== 1'b0 || ill_s !== 1'b1 || ov_u !== 1'b0) begin
          miscompares++;
          $display("FAIL idle k=%0d: v=%b ill=%b, required 0 and held 1",
                   k, ov_s, ill_s);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] b;
      b = $urandom();
      if ($urandom_range(0, 1) == 0) b = $urandom_range(0, 40);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(), b,
            $urandom(), $urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
    end
    vectors++;
    if (q_s.size() != 0 || q_u.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending s=%0d u=%0d, required 0",
               q_s.size(), q_u.size());
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 4'd1, 2, 3, 4, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd1, 5, 6, 7, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    drive(1'b1, 4'd3, 1, 1, 1, 1'b0);
    @(negedge clk);
    Reset = 1'b0;
    q_s.delete();
    q_u.delete();
    for (int k = 0; k < PP + 2; k++) begin
      drive(1'b0, 4'd0, 0, 0, 0, 1'b0);
      @(negedge clk);
      vectors++;
      if ({ov_s, ill_s, out_s} !== 34'd0 ||
          {ov_u, ill_u, out_u} !== 34'd0) begin
        miscompares++;
        $display("FAIL rst_mid k=%0d: v=%b ill=%b out=%h, required 0/0/0",
                 k, ov_s, ill_s, out_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_modes();
    test_stall();
    test_reserved_idle();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
